// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read and write controllers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Default memory address width; pointers carry one extra lap bit.
  localparam int FIFO_ADDR_WIDTH = 3;

  // Functions work on a 32-bit container so any pointer width up to 32
  // can use them; callers zero-extend in and truncate out.
  localparam int FIFO_PTR_MAX = 32;

  function automatic logic [FIFO_PTR_MAX-1:0] bin2gray(input logic [FIFO_PTR_MAX-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic logic [FIFO_PTR_MAX-1:0] gray2bin(input logic [FIFO_PTR_MAX-1:0] gray);
    logic [FIFO_PTR_MAX-1:0] bin;
    bin[FIFO_PTR_MAX-1] = gray[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Gray-to-binary converter for a P-bit pointer (XOR prefix from the MSB down).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module fifo_gray2bin #(
  parameter int P = 4
) (
  input  logic [P-1:0] gray,
  output logic [P-1:0] bin
);

  // Each binary bit is the parity of the gray bits at and above it.
  for (genvar i = 0; i < P; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, empty/almost-empty, fill count.
// Latency: all outputs registered; a write shows here 3 read clocks after it happens.
// Backpressure: reads while EMPTY are dropped and flagged with a one-cycle UNDERFLOW.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RINC,
  input  logic [ADDR_WIDTH:0]   WPTR_SYNC,
  output logic [ADDR_WIDTH-1:0] RADDR,
  output logic [ADDR_WIDTH:0]   RPTR,
  output logic                  EMPTY,
  output logic                  AEMPTY,
  output logic [ADDR_WIDTH:0]   RCOUNT,
  output logic                  UNDERFLOW
);

  localparam int P = ADDR_WIDTH + 1;
  localparam logic [P-1:0] AEMPTY_THR = P'(AEMPTY_LVL);

  logic [P-1:0] rbin;
  logic [P-1:0] rbin_nxt;
  logic [P-1:0] rgray_nxt;
  logic [P-1:0] wbin;
  logic [P-1:0] fill_nxt;
  logic         rd_en;

  fifo_gray2bin #(.P(P)) u_wptr_g2b (
    .gray (WPTR_SYNC),
    .bin  (wbin)
  );

  // Registered EMPTY gates the read, so WPTR_SYNC never reaches rd_en combinationally.
  assign rd_en     = RINC & ~EMPTY;
  assign rbin_nxt  = rbin + P'(rd_en);
  assign rgray_nxt = P'(bin2gray(FIFO_PTR_MAX'(rbin_nxt)));
  // Modulo-2^P difference; the lap bit keeps full (DEPTH) distinct from empty (0).
  assign fill_nxt  = wbin - rbin_nxt;
  assign RADDR     = rbin[ADDR_WIDTH-1:0];

  // Pointer, status and count registers, all judged against the post-read pointer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rbin      <= '0;
      RPTR      <= '0;
      EMPTY     <= 1'b1;
      AEMPTY    <= 1'b1;
      RCOUNT    <= '0;
      UNDERFLOW <= 1'b0;
    end else begin
      rbin      <= rbin_nxt;
      RPTR      <= rgray_nxt;
      EMPTY     <= (rgray_nxt == WPTR_SYNC);
      AEMPTY    <= (fill_nxt <= AEMPTY_THR);
      RCOUNT    <= fill_nxt;
      UNDERFLOW <= RINC & EMPTY;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RINC = 1'b0;
  logic [3:0] WPTR_SYNC = 4'd0;
  logic [2:0] RADDR;
  logic [3:0] RPTR;
  logic       EMPTY;
  logic       AEMPTY;
  logic [3:0] RCOUNT;
  logic       UNDERFLOW;

  int checks = 0;
  int errors = 0;

  // Reference state: total words written / read since reset, as plain integers.
  int  w_tot = 0;
  int  r_tot = 0;
  bit  m_empty = 1'b1;
  bit  m_uf = 1'b0;

  fifo_rd_ctrl #(.ADDR_WIDTH(3), .AEMPTY_LVL(1)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RINC      (RINC),
    .WPTR_SYNC (WPTR_SYNC),
    .RADDR     (RADDR),
    .RPTR      (RPTR),
    .EMPTY     (EMPTY),
    .AEMPTY    (AEMPTY),
    .RCOUNT    (RCOUNT),
    .UNDERFLOW (UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] gray4(input int v);
    int m;
    m = v % 16;
    return 4'(m ^ (m >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the rising
  // edge, then compare every output shortly after it.
  task automatic step(input bit rst_i, input bit rinc_i, input int w_new);
    int avail;
    @(negedge CLK);
    RST       = rst_i;
    RINC      = rinc_i;
    w_tot     = w_new;
    WPTR_SYNC = gray4(w_new);
    @(posedge CLK);
    if (!rst_i) begin
      r_tot   = 0;
      m_empty = 1'b1;
      m_uf    = 1'b0;
      avail   = 0;
    end else begin
      m_uf = rinc_i && m_empty;
      if (rinc_i && !m_empty) r_tot++;
      avail   = w_tot - r_tot;
      m_empty = (avail == 0);
    end
    #1;
    check("raddr",     32'(RADDR),     32'(r_tot % 8));
    check("rptr",      32'(RPTR),      32'(gray4(r_tot)));
    check("empty",     32'(EMPTY),     32'(m_empty));
    check("aempty",    32'(AEMPTY),    32'(avail <= 1));
    check("rcount",    32'(RCOUNT),    32'(avail));
    check("underflow", 32'(UNDERFLOW), 32'(m_uf));
  endtask

  initial begin
    // Reset and idle-empty behaviour, including back-to-back rejected reads.
    step(0, 0, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 0, 0);

    // Four words arrive at once, then are drained one per cycle.
    step(1, 0, 4);
    for (int i = 0; i < 4; i++) step(1, 1, 4);
    step(1, 1, 4);

    // Fill to capacity, then drain all eight across the address wrap.
    step(1, 0, w_tot + 8);
    for (int i = 0; i < 8; i++) step(1, 1, w_tot);
    step(1, 0, w_tot);

    // Read and write together every cycle for a full pointer lap: count holds at 1.
    step(1, 0, w_tot + 1);
    for (int i = 0; i < 16; i++) step(1, 1, w_tot + 1);
    // Same setup without a write: the last word goes and EMPTY rises.
    step(1, 1, w_tot);
    step(1, 0, w_tot);

    // Random traffic with the write pointer advancing at most one step per cycle.
    for (int i = 0; i < 600; i++) begin
      int wn;
      wn = w_tot;
      if (($urandom % 3) != 0 && (w_tot + 1 - r_tot) <= 8) wn = w_tot + 1;
      step(1, bit'($urandom % 2), wn);
    end

    // Reset in mid-stream with a read pending.
    step(0, 0, 0);
    step(1, 0, 7);
    for (int i = 0; i < 5; i++) step(1, 1, 7);
    check("mid_rcount", 32'(RCOUNT), 32'd2);
    check("mid_raddr",  32'(RADDR),  32'd5);
    step(0, 1, 7);
    step(1, 0, 0);
    step(1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
Read-side controller of the asynchronous FIFO, clocked in the read domain. It consumes the Gray-coded write pointer after the double-flop synchronizer has brought it into the read domain. It produces:
- the binary read address for the FIFO memory
- the registered Gray read pointer, which is sent to the write-domain synchronizer
- empty and almost-empty status, a conservative fill count, and an underflow pulse.

Parameters:
- ADDR_WIDTH, 3: memory address width; DEPTH = 2**ADDR_WIDTH; pointer width P = ADDR_WIDTH+1 (4 by default, matching the 4-bit synchronizer bus).
- AEMPTY_LVL, 1: AEMPTY asserts when the fill count is <= this value; legal range 0..DEPTH-1.

Ports:
- CLK  in  1  read-domain clock; all state on posedge CLK.
- RST  in  1  reset; synchronous, active-low.
- RINC  in  1  read request; honoured only when EMPTY=0.
- WPTR_SYNC  in  P  Gray write pointer, already synchronized into the CLK domain.
- RADDR  out  ADDR_WIDTH  memory read address.
- RPTR  out  P  registered Gray read pointer, sent to the write-domain synchronizer.
- EMPTY  out  1  FIFO empty (registered).
- AEMPTY  out  1  almost empty (registered).
- RCOUNT  out  P  entries available to read, as seen from the read domain (registered).
- UNDERFLOW  out  1  one-cycle pulse on a rejected read.

Behaviour:
- Reset (RST=0 at a posedge CLK): rbin=0, RPTR=0, RADDR=0, EMPTY=1, AEMPTY=1, RCOUNT=0, UNDERFLOW=0. Reset mid-operation discards all pointer state on that edge, whatever RINC is.
- Read enable: rd_en = RINC & ~EMPTY. The current registered EMPTY is used, so there is no combinational path from WPTR_SYNC to rd_en.
- Next pointer: rbin_nxt = rbin + rd_en, modulo 2**P. Wrap: P-bit counter, 0 after 2*DEPTH reads; the MSB toggle distinguishes the full and empty laps.
- Gray conversion: rgray_nxt = (rbin_nxt >> 1) ^ rbin_nxt. Registers: rbin <= rbin_nxt; RPTR <= rgray_nxt. RPTR changes at most one bit per cycle.
- RADDR = rbin[ADDR_WIDTH-1:0], taken directly from the register. The memory sees the address of the head entry; data for a read is the word at RADDR in the cycle RINC is accepted.
- Empty: EMPTY <= (rgray_nxt == WPTR_SYNC). This is a full-width Gray compare, including the MSB. It asserts on the same edge that consumes the last word.
- Count: wbin = gray2bin(WPTR_SYNC); RCOUNT <= (wbin - rbin_nxt) mod 2**P. The value is in 0..DEPTH for legal inputs.
- Almost empty: AEMPTY <= (((wbin - rbin_nxt) mod 2**P) <= AEMPTY_LVL). EMPTY implies AEMPTY.
- Underflow: UNDERFLOW <= RINC & EMPTY. The pointer does not move. The pulse lasts one cycle per rejected request, and back-to-back rejected requests give back-to-back pulses.
- Simultaneous read and write-pointer advance in the same cycle: both take effect. Flags and count use the new WPTR_SYNC and rbin_nxt, so the count is unchanged when one write and one read coincide.
- Latency: a write becomes visible only after the synchronizer delay (2 CLK edges) plus one registered compare.
  - EMPTY/RCOUNT are pessimistic: they never report data that is not present.
  - Deassertion of EMPTY lags the write by 3 read clocks.
- WPTR_SYNC must be valid Gray with a count <= DEPTH. Values outside this are not checked; behaviour for them is undefined apart from pointer-wrap consistency.

Decomposition:
- Shared package fifo_pkg holds:
  - default FIFO_ADDR_WIDTH = 3
  - functions bin2gray and gray2bin (width-generic via P)
  - the same package is also used by the write-side controller.
- One natural sub-module: fifo_gray2bin. It is combinational, parameter P, an XOR prefix from the MSB down, and is instanced for WPTR_SYNC.
- Everything else stays flat in fifo_rd_ctrl.

Test Plan:
1. Reset, then hold with WPTR_SYNC=0 -> EMPTY=1, AEMPTY=1, RCOUNT=0, RPTR=0, RADDR=0; RINC=1 for 2 cycles -> UNDERFLOW=1 for 2 cycles, RPTR stays 0.
2. Drive WPTR_SYNC=4'b0110 (bin 4) -> next edge: EMPTY=0, RCOUNT=4, AEMPTY=0. Then 4 consecutive RINC -> RADDR 0,1,2,3; RPTR 0001,0011,0010,0110. EMPTY=1 on the 4th read edge; AEMPTY=1 once RCOUNT=1.
3. Full FIFO: WPTR_SYNC=gray(8)=4'b1100 from rbin=0 -> RCOUNT=8. Read 8 -> RADDR wraps 7->0, rbin=8, RPTR=1100, EMPTY=1.
4. Pointer wrap: cycle 16 writes and 16 reads interleaved -> rbin returns 0 and RPTR returns 0000. No false EMPTY while RCOUNT>0, and no UNDERFLOW.
5. Simultaneous: RCOUNT=1, RINC=1 in the same cycle WPTR_SYNC advances by 1 -> RCOUNT stays 1, EMPTY stays 0. With the same setup but no advance -> EMPTY=1.
6. Reset mid-stream: rbin=5, RCOUNT=2, RST=0 for one edge with RINC=1 -> all outputs return to reset values on that edge and UNDERFLOW=0.
